// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, word width and synchronizer depth.
package spi_pkg;

  localparam int SPI_WORD_W      = 16;
  localparam int SPI_SYNC_STAGES = 3;
  localparam int SPI_CNT_W       = 5;

  localparam logic [SPI_CNT_W-1:0] SPI_FULL_CNT = SPI_CNT_W'(SPI_WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_OVER  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer; last two stages give one-clk rise/fall strobes.
module spi_sync #(
  parameter int   N       = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= {N{RST_VAL}};
    else        sr_q <= {sr_q[N-2:0], d_i};
  end

  assign q_o    = sr_q[N-1];
  assign rise_o = sr_q[N-2] & ~sr_q[N-1];
  assign fall_o = ~sr_q[N-2] & sr_q[N-1];

endmodule

// File: rtl/spi_slv.sv
// SPI mode-3 style slave: 16-bit frames, MSB first, oversampled on clk.
// Optional frm_err pulse output when SPI_SLV_FRM_ERR_EN is defined.
module spi_slv
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [SPI_WORD_W-1:0] tx_data,
  output logic [SPI_WORD_W-1:0] rx_cmd,
  output logic                  cmd_rdy,
  output logic                  busy
`ifdef SPI_SLV_FRM_ERR_EN
  ,
  output logic                  frm_err
`endif
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_rise, ss_fall, ss_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_state_e             state_q, state_d;
  logic [SPI_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SPI_WORD_W-1:0]  rx_shft_q, rx_shft_d;
  logic [SPI_WORD_W-1:0]  tx_shft_q, tx_shft_d;
  logic [SPI_WORD_W-1:0]  rx_cmd_q, rx_cmd_d;
  logic                   cmd_rdy_q, cmd_rdy_d;

  spi_sync #(.N(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.N(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .q_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI only needs delay so its last stage lines up with the SCLK rise strobe.
  spi_sync #(.N(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_shft_q <= '0;
      tx_shft_q <= '0;
      rx_cmd_q  <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_shft_q <= rx_shft_d;
      tx_shft_q <= tx_shft_d;
      rx_cmd_q  <= rx_cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_shft_d = rx_shft_q;
    tx_shft_d = tx_shft_q;
    rx_cmd_d  = rx_cmd_q;
    cmd_rdy_d = 1'b0;
    if (ss_fall) begin
      state_d   = ST_ARMED;
      bit_cnt_d = '0;
      rx_shft_d = '0;
      tx_shft_d = tx_data;
    end else if (ss_rise) begin
      if (bit_cnt_q == SPI_FULL_CNT) begin
        rx_cmd_d  = rx_shft_q;
        cmd_rdy_d = 1'b1;
      end
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[SPI_WORD_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
            // An extra rise overruns the word: freeze rx_shft and spoil the count.
            if (bit_cnt_q == SPI_FULL_CNT) state_d = ST_OVER;
            else rx_shft_d = {rx_shft_q[SPI_WORD_W-2:0], mosi_s};
          end else if (sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q < SPI_FULL_CNT)) begin
            tx_shft_d = {tx_shft_q[SPI_WORD_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    MISO = 1'b0;
    if (state_q != ST_IDLE) MISO = tx_shft_q[SPI_WORD_W-1];
  end

  assign rx_cmd  = rx_cmd_q;
  assign cmd_rdy = cmd_rdy_q;

`ifdef SPI_SLV_FRM_ERR_EN
  logic frm_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frm_err_q <= 1'b0;
    else        frm_err_q <= (state_q != ST_IDLE) &&
                             (ss_fall || (ss_rise && (bit_cnt_q != SPI_FULL_CNT)));
  end

  assign frm_err = frm_err_q;
`endif

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv acting as SPI initiator; build with SPI_SLV_FRM_ERR_EN to cover frm_err.
module tb_spi_slv;
  import spi_pkg::*;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b1;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [15:0] tx_data = '0;
  logic [15:0] rx_cmd;
  logic        cmd_rdy;
  logic        busy;
`ifdef SPI_SLV_FRM_ERR_EN
  logic        frm_err;
`endif

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int rdy0, err0, lat;
  logic [15:0] rd;
  logic        busy_seen;

  spi_slv dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .rx_cmd(rx_cmd), .cmd_rdy(cmd_rdy), .busy(busy)
`ifdef SPI_SLV_FRM_ERR_EN
    , .frm_err(frm_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_rdy === 1'b1) rdy_cnt++;
`ifdef SPI_SLV_FRM_ERR_EN
    if (frm_err === 1'b1) err_cnt++;
`endif
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves SS_n low; chg_at >= 0 zeroes tx_data after that rise.
  task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_at,
                       output logic [15:0] rdv, output logic bsy);
    rdv = '0;
    bsy = 1'b0;
    SS_n = 1'b0;
    clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      clks(HALF);
      rdv = {rdv[14:0], MISO};
      SCLK = 1'b1;
      if (i == 0) bsy = busy;
      if (i == chg_at) tx_data = 16'h0000;
      clks(HALF);
    end
  endtask

  task automatic end_frame(output int latency);
    latency = 99;
    SS_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && latency == 99) latency = k;
    end
    clks(2);
  endtask

  initial begin
    clks(3);
    check("rst_rx_cmd", 32'(rx_cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_miso", 32'(MISO), 32'h0);
    rst_n = 1'b1;
    clks(4);

    // basic frame
    tx_data = 16'h1234;
    rdy0 = rdy_cnt; err0 = err_cnt;
    frame(16'hA5C3, 16, -1, rd, busy_seen);
    end_frame(lat);
    check("basic_busy", 32'(busy_seen), 32'h1);
    check("basic_master_rd", 32'(rd), 32'h1234);
    check("basic_rx_cmd", 32'(rx_cmd), 32'hA5C3);
    check("basic_rdy_pulses", 32'(rdy_cnt - rdy0), 32'd1);
    check("basic_rdy_latency", 32'(lat), 32'd4);
    check("basic_busy_after", 32'(busy), 32'h0);
`ifdef SPI_SLV_FRM_ERR_EN
    check("basic_frm_err", 32'(err_cnt - err0), 32'd0);
`endif

    // short frame of 10 rises
    rdy0 = rdy_cnt; err0 = err_cnt;
    frame(16'h3C3C, 10, -1, rd, busy_seen);
    end_frame(lat);
    check("short_rdy_pulses", 32'(rdy_cnt - rdy0), 32'd0);
    check("short_rx_cmd_hold", 32'(rx_cmd), 32'hA5C3);
`ifdef SPI_SLV_FRM_ERR_EN
    check("short_frm_err", 32'(err_cnt - err0), 32'd1);
`endif

    // back-to-back frames, 3 clk SS_n high gap
    rdy0 = rdy_cnt;
    frame(16'hFFFF, 16, -1, rd, busy_seen);
    SS_n = 1'b1;
    clks(3);
    frame(16'h5A3C, 16, -1, rd, busy_seen);
    end_frame(lat);
    check("b2b_rdy_pulses", 32'(rdy_cnt - rdy0), 32'd2);
    check("b2b_rx_cmd", 32'(rx_cmd), 32'h5A3C);
    check("b2b_master_rd2", 32'(rd), 32'h1234);

    // overrun: 17 rises
    rdy0 = rdy_cnt; err0 = err_cnt;
    frame(16'h0F0F, 17, -1, rd, busy_seen);
    check("over_state", 32'(dut.state_q), 32'(ST_OVER));
    end_frame(lat);
    check("over_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("over_rdy_pulses", 32'(rdy_cnt - rdy0), 32'd0);
    check("over_rx_cmd_hold", 32'(rx_cmd), 32'h5A3C);
`ifdef SPI_SLV_FRM_ERR_EN
    check("over_frm_err", 32'(err_cnt - err0), 32'd1);
`endif

    // reset after 8 bits
    rdy0 = rdy_cnt;
    frame(16'h0F0F, 8, -1, rd, busy_seen);
    rst_n = 1'b0;
    clks(1);
    check("midrst_rx_cmd", 32'(rx_cmd), 32'h0);
    check("midrst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_miso", 32'(MISO), 32'h0);
    SS_n = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(6);
    check("midrst_wait_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("midrst_no_rdy", 32'(rdy_cnt - rdy0), 32'd0);
    frame(16'h8001, 16, -1, rd, busy_seen);
    end_frame(lat);
    check("postrst_rx_cmd", 32'(rx_cmd), 32'h8001);
    check("postrst_rdy_pulses", 32'(rdy_cnt - rdy0), 32'd1);

    // tx_data changes mid-frame
    tx_data = 16'hBEEF;
    clks(2);
    frame(16'h1357, 16, 3, rd, busy_seen);
    end_frame(lat);
    check("txchg_master_rd", 32'(rd), 32'hBEEF);
    check("txchg_rx_cmd", 32'(rx_cmd), 32'h1357);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
